arbpuf_eval_ctrl: RTL and testbench
===================================

Name: arbpuf_eval_ctrl

Overview:
- Sequencer for one arbiter-PUF delay chain, on the consumer side of the switch stages.
- Accepts a challenge over a valid/ready handshake and drives it onto the chain's per-stage challenge inputs, held stable for the whole evaluation.
- Repeatedly clears the end-of-chain arbiter latch, fires a launch edge, synchronises the arbiter result and counts ones.
- Emits a majority-voted response bit plus a confidence count over valid/ready.

Parameters:
- N_STAGES, 64: number of switch stages; challenge width.
- N_EVAL, 15: evaluations per challenge. Must be odd and ≥1; any other value is an elaboration error.
- SETTLE_CYC, 8: cycles allowed for the race to settle, and for the chain to discharge after clear. Must be ≥1.
- SYNC_STAGES, 2: flip-flop depth of the arb_in synchroniser. Must be ≥2.
- CW, $clog2(N_EVAL+1): width of the ones counter and resp_conf (derived).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- chal_in  in  N_STAGES  challenge word.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  challenge accepted when chal_valid && chal_ready.
- chain_chal  out  N_STAGES  per-stage challenge bits to the switch chain.
- launch  out  1  rising edge injected into both chain inputs.
- arb_clr  out  1  holds the arbiter latch cleared.
- arb_in  in  1  asynchronous arbiter output; goes through a SYNC_STAGES synchroniser.
- resp  out  1  majority-voted response.
- resp_conf  out  CW  number of evaluations that returned 1.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, chain_chal=0, launch=0, arb_clr=1, resp=0, resp_conf=0, resp_valid=0, busy=0, all counters=0, synchroniser=0.
  - Asserting rst_n low mid-evaluation forces these values immediately; no partial response is ever emitted.
- All outputs are registered.
- chal_ready = (state==IDLE).
- IDLE:
  - On accept: chain_chal<=chal_in, eval_cnt<=0, ones<=0, go to CLEAR.
  - chain_chal changes only on an accept.
- CLEAR: launch=0, arb_clr=1, held for SETTLE_CYC cycles, then go to LAUNCH.
- LAUNCH: 1 cycle; arb_clr<=0, launch<=1, then go to SETTLE.
- SETTLE:
  - launch stays 1, arb_clr stays 0.
  - Waits SETTLE_CYC+SYNC_STAGES cycles so the synchronised arb_in reflects the race.
  - Then go to SAMPLE.
- SAMPLE: 1 cycle.
  - ones<=ones+arb_sync; eval_cnt<=eval_cnt+1.
  - If eval_cnt+1==N_EVAL, go to DONE; otherwise go to CLEAR.
  - launch<=0 and arb_clr<=1 on exit.
- DONE:
  - On entry: resp<=(final ones > N_EVAL/2), resp_conf<=final ones (including this sample), resp_valid<=1.
  - Holds until resp_ready. On handshake: resp_valid<=0, go to IDLE.
  - resp and resp_conf keep their last value until the next DONE.
- Latency:
  - Per evaluation: 2*SETTLE_CYC+SYNC_STAGES+2 cycles.
  - resp_valid rises exactly N_EVAL*(2*SETTLE_CYC+SYNC_STAGES+2)+1 cycles after the accepting edge.
  - With defaults: 20 cycles per evaluation, 301 cycles total.
- Backpressure: resp_valid, resp and resp_conf stay stable while resp_ready=0. chal_ready stays 0, so no new challenge is taken.
- Back-to-back: the earliest next accept is the cycle after the response handshake (IDLE is 1 cycle minimum).
- Width: ones saturates by construction (max N_EVAL ≤ 2^CW−1); no wrap.
- Only the synchronised arb_in is used; arb_in changing during CLEAR or LAUNCH has no effect.

Test Plan:
1. Reset: hold rst_n=0 with arbitrary inputs -> arb_clr=1, launch=0, chal_ready=0 during reset; after release chal_ready=1, resp_valid=0, chain_chal=0.
2. Stable 1: bench arbiter model returns 1 on every launch, chal_in=64'hA5A5_5A5A_F00F_0FF0 -> resp=1, resp_conf=15, resp_valid at +301 cycles; chain_chal equals the challenge throughout; 15 launch pulses observed.
3. Vote threshold: model returns 1 on exactly 7 of 15 launches -> resp=0, resp_conf=7; repeat with 8 of 15 -> resp=1, resp_conf=8.
4. Backpressure: resp_ready=0 for 50 cycles after resp_valid while chal_valid=1 with a new challenge -> resp and resp_conf stable, chal_ready=0, chain_chal unchanged; resp_ready=1 -> handshake, then the new challenge is accepted the next cycle.
5. Reset mid-operation: pulse rst_n low during SETTLE of evaluation 5 -> launch=0 and arb_clr=1 asynchronously; a subsequent challenge with an all-0 model yields resp=0, resp_conf=0 (no residual count).
6. Synchroniser timing: model toggles arb_in 1 cycle before SAMPLE -> the sampled value is the pre-toggle value.

Source files
------------

// File: rtl/arbpuf_eval_ctrl.sv
// Evaluation sequencer for one arbiter-PUF delay chain: holds the challenge, repeats
// clear/launch/settle/sample N_EVAL times and returns a majority vote plus ones count.
module arbpuf_eval_ctrl #(
  parameter int unsigned N_STAGES    = 64,
  parameter int unsigned N_EVAL      = 15,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CW          = $clog2(N_EVAL + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_STAGES-1:0] chal_in,
  input  logic                chal_valid,
  output logic                chal_ready,
  output logic [N_STAGES-1:0] chain_chal,
  output logic                launch,
  output logic                arb_clr,
  input  logic                arb_in,
  output logic                resp,
  output logic [CW-1:0]       resp_conf,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                busy
);

  localparam int unsigned WaitCyc = SETTLE_CYC + SYNC_STAGES;
  localparam int unsigned TW      = $clog2(WaitCyc + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StClear  = 3'd1;
  localparam logic [2:0] StLaunch = 3'd2;
  localparam logic [2:0] StSettle = 3'd3;
  localparam logic [2:0] StSample = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  if (N_EVAL < 1 || (N_EVAL % 2) != 1) begin : g_bad_n_eval
    $error("N_EVAL must be odd and >= 1");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("SETTLE_CYC must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end

  logic [2:0]             state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          eval_cnt_q, eval_cnt_d;
  logic [CW-1:0]          ones_q, ones_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   arb_sync;
  logic                   fire;

  assign arb_sync = sync_q[SYNC_STAGES-1];
  // Launch is held high from the end of StLaunch until the sample has been taken.
  assign fire     = (state_d == StSettle) || (state_d == StSample);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    eval_cnt_d = eval_cnt_q;
    ones_d     = ones_q;
    case (state_q)
      StIdle: begin
        if (chal_valid && chal_ready) begin
          state_d    = StClear;
          timer_d    = '0;
          eval_cnt_d = '0;
          ones_d     = '0;
        end
      end
      StClear: begin
        if (timer_q == TW'(SETTLE_CYC - 1)) begin
          state_d = StLaunch;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StLaunch: state_d = StSettle;
      StSettle: begin
        if (timer_q == TW'(WaitCyc - 1)) begin
          state_d = StSample;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StSample: begin
        ones_d     = ones_q + CW'(arb_sync);
        eval_cnt_d = eval_cnt_q + 1'b1;
        state_d    = (eval_cnt_d == CW'(N_EVAL)) ? StDone : StClear;
      end
      StDone: begin
        if (resp_valid && resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      eval_cnt_q <= '0;
      ones_q     <= '0;
      sync_q     <= '0;
      chal_ready <= 1'b0;
      busy       <= 1'b0;
      chain_chal <= '0;
      launch     <= 1'b0;
      arb_clr    <= 1'b1;
      resp       <= 1'b0;
      resp_conf  <= '0;
      resp_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      eval_cnt_q <= eval_cnt_d;
      ones_q     <= ones_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], arb_in};
      chal_ready <= (state_d == StIdle);
      busy       <= (state_d != StIdle);
      launch     <= fire;
      arb_clr    <= !fire;
      if (state_q == StIdle && state_d == StClear) chain_chal <= chal_in;
      // First cycle in StDone publishes the vote; it then holds until consumed.
      if (state_q == StDone && !resp_valid) begin
        resp_valid <= 1'b1;
        resp       <= (ones_q > CW'(N_EVAL / 2));
        resp_conf  <= ones_q;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbpuf_eval_ctrl.sv
// Self-checking bench for arbpuf_eval_ctrl: vector table with a response scoreboard,
// plus hand-written backpressure, mid-run reset and synchroniser timing sequences.
module tb_arbpuf_eval_ctrl;

  localparam int LAT = 301;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] chal_in = '0;
  logic        chal_valid = 1'b0;
  logic        chal_ready;
  logic [63:0] chain_chal;
  logic        launch;
  logic        arb_clr;
  logic        arb_in = 1'b0;
  logic        resp;
  logic [3:0]  resp_conf;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        busy;

  arbpuf_eval_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chal_in    (chal_in),
    .chal_valid (chal_valid),
    .chal_ready (chal_ready),
    .chain_chal (chain_chal),
    .launch     (launch),
    .arb_clr    (arb_clr),
    .arb_in     (arb_in),
    .resp       (resp),
    .resp_conf  (resp_conf),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] chal;
    logic [14:0] pat;
    logic [14:0] tog;
    logic        exp_resp;
    logic [3:0]  exp_conf;
  } vec_t;

  typedef struct {
    logic       r;
    logic [3:0] c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Arbiter model: on each launch rise, output pat[k]; optionally flip it 9 cycles later,
  // which is the last cycle before the controller samples.
  logic [14:0] pat = '0;
  logic [14:0] tog = '0;
  int          pat_base = 0;
  int          launch_cnt = 0;
  int          cyc = 0;
  int          idx = 0;
  logic        launch_prev = 1'b0;
  logic        cur_tog = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      arb_in      = 1'b0;
      launch_prev = 1'b0;
    end else begin
      if (launch && !launch_prev) begin
        idx        = launch_cnt - pat_base;
        arb_in     = (idx >= 0 && idx < 15) ? pat[idx] : 1'b0;
        cur_tog    = (idx >= 0 && idx < 15) ? tog[idx] : 1'b0;
        launch_cnt = launch_cnt + 1;
        cyc        = 0;
      end else if (launch) begin
        cyc = cyc + 1;
        if (cyc == 9 && cur_tog) arb_in = ~arb_in;
      end else begin
        arb_in = 1'b0;
      end
      launch_prev = launch;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1; returns just after the accepting edge.
  task automatic start_chal(input logic [63:0] c, input logic [14:0] p, input logic [14:0] t,
                            input logic er, input logic [3:0] ec);
    int   n = 0;
    exp_t e;
    while (!chal_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("chal_ready_idle", chal_ready, 1);
    pat        = p;
    tog        = t;
    pat_base   = launch_cnt;
    chal_in    = c;
    chal_valid = 1'b1;
    e.r        = er;
    e.c        = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chal_valid = 1'b0;
  endtask

  task automatic wait_resp(input logic [63:0] c, input string tag);
    int   n = 0;
    int   bad = 0;
    exp_t e;
    while (!resp_valid && n < 400) begin
      if (chain_chal !== c) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_chain_stable"}, bad, 0);
    check({tag, "_launches"}, launch_cnt - pat_base, 15);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got response with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_resp"}, resp, e.r);
      check({tag, "_conf"}, resp_conf, e.c);
    end
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, resp_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t v[7];
    int   bad;
    v[0] = '{64'hA5A5_5A5A_F00F_0FF0, 15'h7FFF, 15'h0000, 1'b1, 4'd15};
    v[1] = '{64'h0123_4567_89AB_CDEF, 15'h007F, 15'h0000, 1'b0, 4'd7};
    v[2] = '{64'hFEDC_BA98_7654_3210, 15'h00FF, 15'h0000, 1'b1, 4'd8};
    v[3] = '{64'h5555_AAAA_5555_AAAA, 15'h5555, 15'h0000, 1'b1, 4'd8};
    v[4] = '{64'h0000_0000_0000_0001, 15'h0000, 15'h0000, 1'b0, 4'd0};
    v[5] = '{64'hC0FF_EE00_1234_ABCD, 15'h000F, 15'h00FF, 1'b0, 4'd4};
    v[6] = '{64'h8000_0000_0000_0000, 15'h7FF0, 15'h7FFF, 1'b1, 4'd11};

    // Reset with arbitrary inputs offered.
    rst_n      = 1'b0;
    chal_in    = 64'hDEAD_BEEF_CAFE_F00D;
    chal_valid = 1'b1;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arb_clr", arb_clr, 1);
    check("rst_launch", launch, 0);
    check("rst_chal_ready", chal_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    rst_n      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_chal_ready", chal_ready, 1);
    check("post_rst_resp_valid", resp_valid, 0);
    check("post_rst_chain_chal", chain_chal, 0);
    check("post_rst_conf", resp_conf, 0);

    for (int i = 0; i < 7; i++) begin
      start_chal(v[i].chal, v[i].pat, v[i].tog, v[i].exp_resp, v[i].exp_conf);
      check($sformatf("v%0d_busy", i), busy, 1);
      wait_resp(v[i].chal, $sformatf("v%0d", i));
      handshake($sformatf("v%0d", i));
    end

    // Backpressure with a new challenge waiting.
    start_chal(64'h1234_5678_9ABC_DEF0, 15'h03FF, 15'h0000, 1'b1, 4'd10);
    wait_resp(64'h1234_5678_9ABC_DEF0, "bp");
    chal_in    = 64'h0BAD_F00D_0BAD_F00D;
    chal_valid = 1'b1;
    bad        = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (resp !== 1'b1 || resp_conf !== 4'd10 || resp_valid !== 1'b1 ||
          chal_ready !== 1'b0 || chain_chal !== 64'h1234_5678_9ABC_DEF0) bad++;
    end
    check("bp_hold_stable", bad, 0);
    begin
      exp_t e;
      e.r = 1'b0;
      e.c = 4'd1;
      pat      = 15'h0001;
      tog      = 15'h0000;
      pat_base = launch_cnt;
      sb.push_back(e);
    end
    handshake("bp");
    check("bp_ready_after_hs", chal_ready, 1);
    @(posedge clk);
    #1;
    chal_valid = 1'b0;
    check("bp_next_accept_chain", chain_chal, 64'h0BAD_F00D_0BAD_F00D);
    check("bp_next_accept_busy", busy, 1);
    wait_resp(64'h0BAD_F00D_0BAD_F00D, "bp2");
    handshake("bp2");

    // Reset during SETTLE of evaluation 5.
    start_chal(64'hFFFF_0000_FFFF_0000, 15'h7FFF, 15'h0000, 1'b1, 4'd15);
    repeat (93) @(posedge clk);
    #1;
    check("mr_pre_launch", launch, 1);
    check("mr_pre_arb_clr", arb_clr, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_async_launch", launch, 0);
    check("mr_async_arb_clr", arb_clr, 1);
    check("mr_async_resp_valid", resp_valid, 0);
    check("mr_async_busy", busy, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start_chal(64'h0F0F_0F0F_0F0F_0F0F, 15'h0000, 15'h0000, 1'b0, 4'd0);
    wait_resp(64'h0F0F_0F0F_0F0F_0F0F, "mr_after");
    handshake("mr_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
